// File: rtl/tk1_spi_pkg.sv
// Shared constants and encodings for the tk1 SPI flash reader.
package tk1_spi_pkg;

  localparam logic [7:0] SPI_FLASH_READ      = 8'h03;
  localparam logic [7:0] SPI_FLASH_FAST_READ = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_SEND, ST_WAIT_LO, ST_WAIT_HI, ST_DESELECT, ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    PH_OPCODE, PH_ADDR2, PH_ADDR1, PH_ADDR0, PH_DUMMY, PH_DATA
  } phase_e;

endpackage

// File: rtl/tk1_spi_flash_reader_if.sv
// Request, read-stream and SPI-master signals of the flash reader.
interface tk1_spi_flash_reader_if;
  logic        cmd_start;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        busy;
  logic        done;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        spi_enable;
  logic        spi_enable_vld;
  logic        spi_start;
  logic [7:0]  spi_tx_data;
  logic        spi_tx_data_vld;
  logic [7:0]  spi_rx_data;
  logic        spi_ready;

  modport slave (
    input  cmd_start, cmd_addr, cmd_len, rd_ready, spi_rx_data, spi_ready,
    output busy, done, rd_data, rd_valid, spi_enable, spi_enable_vld,
           spi_start, spi_tx_data, spi_tx_data_vld
  );

  modport master (
    output cmd_start, cmd_addr, cmd_len, rd_ready, spi_rx_data, spi_ready,
    input  busy, done, rd_data, rd_valid, spi_enable, spi_enable_vld,
           spi_start, spi_tx_data, spi_tx_data_vld
  );
endinterface

// File: rtl/tk1_spi_rx_fifo.sv
// Synchronous receive FIFO; head byte is visible the cycle after its push.
module tk1_spi_rx_fifo #(
  parameter  int RX_FIFO_DEPTH = 8,
  localparam int AW = $clog2(RX_FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic [7:0]  push_data_i,
  input  logic        pop_i,
  output logic [7:0]  pop_data_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);
  logic [7:0]    mem_q [RX_FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rptr_q];
  assign full_o     = (cnt_q == (AW+1)'(RX_FIFO_DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;
endmodule

// File: rtl/tk1_spi_flash_reader.sv
// SPI flash read sequencer: CS on, opcode + 24-bit address (+ dummy), N data bytes into FIFO, CS off.
// TK1_SPI_FLASH_FAST_READ_EN selects fast read (0x0B + one dummy byte) instead of 0x03.
module tk1_spi_flash_reader
  import tk1_spi_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 8
) (
  input logic                    clk,
  input logic                    reset,
  tk1_spi_flash_reader_if.slave  bus
);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
`ifdef TK1_SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE         = SPI_FLASH_FAST_READ;
  localparam phase_e     PH_AFTER_ADDR0 = PH_DUMMY;
`else
  localparam logic [7:0] OPCODE         = SPI_FLASH_READ;
  localparam phase_e     PH_AFTER_ADDR0 = PH_DATA;
`endif

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  rem_q, rem_d;
  logic        zdone_q, zdone_d;
  logic        rstvld_q;
  logic        push, pop, fifo_full, fifo_empty, send_ok, start;
  logic [7:0]  tx_byte;
  logic [AW:0] fifo_cnt;
  logic        unused_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_OPCODE;
      addr_q   <= '0;
      rem_q    <= '0;
      zdone_q  <= 1'b0;
      rstvld_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      zdone_q  <= zdone_d;
      rstvld_q <= 1'b0;
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    case (phase_q)
      PH_OPCODE: tx_byte = OPCODE;
      PH_ADDR2:  tx_byte = addr_q[23:16];
      PH_ADDR1:  tx_byte = addr_q[15:8];
      PH_ADDR0:  tx_byte = addr_q[7:0];
      default:   tx_byte = 8'h00;
    endcase
  end

  // Data bytes wait for FIFO room before clocking; header bytes never stall.
  assign send_ok = bus.spi_ready && !(phase_q == PH_DATA && fifo_full);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    zdone_d = 1'b0;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.cmd_start) begin
        if (bus.cmd_len != 8'd0) begin
          addr_d  = bus.cmd_addr;
          rem_d   = bus.cmd_len;
          state_d = ST_SELECT;
        end else begin
          zdone_d = 1'b1;
        end
      end
      ST_SELECT: begin
        phase_d = PH_OPCODE;
        state_d = ST_SEND;
      end
      ST_SEND:    if (send_ok) state_d = ST_WAIT_LO;
      ST_WAIT_LO: if (!bus.spi_ready) state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (bus.spi_ready) begin
        state_d = ST_SEND;
        case (phase_q)
          PH_OPCODE: phase_d = PH_ADDR2;
          PH_ADDR2:  phase_d = PH_ADDR1;
          PH_ADDR1:  phase_d = PH_ADDR0;
          PH_ADDR0:  phase_d = PH_AFTER_ADDR0;
          PH_DUMMY:  phase_d = PH_DATA;
          default: begin
            push  = 1'b1;
            rem_d = rem_q - 8'd1;
            if (rem_q == 8'd1) state_d = ST_DESELECT;
          end
        endcase
      end
      ST_DESELECT: state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign start = (state_q == ST_SEND) && send_ok;

  always_comb begin
    bus.busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
    bus.done            = (state_q == ST_DONE) || zdone_q;
    bus.spi_enable      = (state_q == ST_SELECT) || (state_q == ST_SEND) ||
                          (state_q == ST_WAIT_LO) || (state_q == ST_WAIT_HI);
    // Strobing during and right after reset releases CS even if only this block was reset.
    bus.spi_enable_vld  = reset || rstvld_q || (state_q == ST_SELECT) || (state_q == ST_DESELECT);
    bus.spi_start       = start;
    bus.spi_tx_data_vld = start;
    bus.spi_tx_data     = (state_q == ST_SEND) ? tx_byte : 8'h00;
  end

  assign pop          = bus.rd_ready && !fifo_empty;
  assign bus.rd_valid = !fifo_empty;
  assign unused_cnt   = ^fifo_cnt;

  tk1_spi_rx_fifo #(.RX_FIFO_DEPTH(RX_FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (bus.spi_rx_data),
    .pop_i       (pop),
    .pop_data_o  (bus.rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );
endmodule

// File: tb/tb_tk1_spi_flash_reader.sv
// Scoreboard bench: flash/SPI-master model decodes the address it is sent and returns flash contents.
module tb_tk1_spi_flash_reader;
  import tk1_spi_pkg::*;
`ifdef TK1_SPI_FLASH_FAST_READ_EN
  localparam int         HDR = 5;
  localparam logic [7:0] OPC = SPI_FLASH_FAST_READ;
`else
  localparam int         HDR = 4;
  localparam logic [7:0] OPC = SPI_FLASH_READ;
`endif
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tk1_spi_flash_reader_if bus();
  tk1_spi_flash_reader #(.RX_FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0, errors = 0;
  logic [7:0] exp_tx[$], exp_rd[$], rx_script[$];
  int done_cnt = 0, start_cnt = 0, en_on_cnt = 0, en_off_cnt = 0, ev_cnt = 0, over1_cnt = 0;

  function automatic logic [7:0] flash(input logic [23:0] a);
    return a[7:0] + 8'(a[15:8] * 3) + 8'(a[23:16] * 7) + 8'h5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // SPI master + flash model and output monitor, evaluated away from the active edge.
  logic        cs = 1'b0, pend = 1'b0;
  int          byte_idx = 0, lat = 0;
  logic [23:0] seen_addr = '0;
  always @(negedge clk) begin : mon
    logic st, tv, ev, en, pop;
    logic [7:0] td, rdd;
    st = bus.spi_start; tv = bus.spi_tx_data_vld; td = bus.spi_tx_data;
    ev = bus.spi_enable_vld; en = bus.spi_enable;
    pop = bus.rd_valid && bus.rd_ready; rdd = bus.rd_data;
    if (reset) begin
      pend = 1'b0; cs = 1'b0; bus.spi_ready = 1'b1;
    end else begin
      if (bus.done) done_cnt++;
      if (dut.fifo_cnt > 1) over1_cnt++;
      if (ev) begin
        if (en) begin
          ev_cnt++; en_on_cnt++; cs = 1'b1; byte_idx = 0;
        end else if (cs) begin
          ev_cnt++; en_off_cnt++; cs = 1'b0;
        end
      end
      if (pend) begin
        bus.spi_ready = 1'b0; pend = 1'b0; lat = $urandom_range(1, 3);
      end else if (!bus.spi_ready) begin
        lat--;
        if (lat == 0) begin
          if (byte_idx < HDR) bus.spi_rx_data = 8'($urandom);
          else if (rx_script.size() != 0) bus.spi_rx_data = rx_script.pop_front();
          else bus.spi_rx_data = flash(seen_addr + 24'(byte_idx - HDR));
          bus.spi_ready = 1'b1;
          byte_idx++;
        end
      end
      if (st) begin
        start_cnt++;
        chk("cs_at_start", cs, 1);
        chk("tx_vld", tv, 1);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_extra actual=%0h expected=none", td);
        end else chk("tx_byte", td, exp_tx.pop_front());
        if (byte_idx >= 1 && byte_idx <= 3) seen_addr = {seen_addr[15:0], td};
        pend = 1'b1;
      end
      if (pop) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_extra actual=%0h expected=none", rdd);
        end else chk("rd_data", rdd, exp_rd.pop_front());
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [23:0] a, input logic [7:0] l);
    if (l != 0) begin
      exp_tx.push_back(OPC);
      exp_tx.push_back(a[23:16]); exp_tx.push_back(a[15:8]); exp_tx.push_back(a[7:0]);
      if (HDR == 5) exp_tx.push_back(8'h00);
      for (int i = 0; i < l; i++) begin
        exp_tx.push_back(8'h00);
        if (rx_script.size() != 0) exp_rd.push_back(rx_script[i]);
        else exp_rd.push_back(flash(a + 24'(i)));
      end
    end
    bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_start = 1'b1;
    step();
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < 3000) begin step(); n++; end
    chk({nm, "_done_seen"}, done_cnt - d0, 1);
    step(3);
    chk({nm, "_done_once"}, done_cnt - d0, 1);
    chk({nm, "_busy_low"}, bus.busy, 0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_rd_valid"}, bus.rd_valid, 0);
    chk({nm, "_start"}, bus.spi_start, 0);
    chk({nm, "_tx_data"}, bus.spi_tx_data, 0);
    chk({nm, "_tx_vld"}, bus.spi_tx_data_vld, 0);
    chk({nm, "_enable"}, bus.spi_enable, 0);
    chk({nm, "_enable_vld"}, bus.spi_enable_vld, 1);
  endtask

  initial begin
    int s0, e0, on0, off0, o0, n;
    logic [23:0] a;
    logic [7:0] l;
    bus.cmd_start = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.rd_ready = 1'b0; bus.spi_ready = 1'b1; bus.spi_rx_data = '0;

    // reset values, and the strobe persisting one cycle past release
    step(3);
    chk_reset_outs("rst");
    reset = 1'b0;
    #1 chk("rst_release_vld", bus.spi_enable_vld, 1);
    step();
    chk("post_release_vld", bus.spi_enable_vld, 0);

    // directed read AA,BB,CC
    bus.rd_ready = 1'b1;
    on0 = en_on_cnt; off0 = en_off_cnt;
    rx_script = '{8'hAA, 8'hBB, 8'hCC};
    issue(24'h012345, 8'd3);
    chk("sel_busy", bus.busy, 1);
    chk("sel_enable", bus.spi_enable, 1);
    chk("sel_enable_vld", bus.spi_enable_vld, 1);
    wait_done("basic");
    chk("basic_cs_on", en_on_cnt - on0, 1);
    chk("basic_cs_off", en_off_cnt - off0, 1);
    chk("basic_rd_left", exp_rd.size(), 0);

    // zero-length request
    s0 = start_cnt; e0 = ev_cnt;
    issue(24'hABCDEF, 8'd0);
    chk("zero_done", bus.done, 1);
    chk("zero_busy", bus.busy, 0);
    step();
    chk("zero_done_pulse", bus.done, 0);
    step(5);
    chk("zero_no_start", start_cnt - s0, 0);
    chk("zero_no_strobe", ev_cnt - e0, 0);

    // FIFO-full stall with consumer held off
    bus.rd_ready = 1'b0;
    s0 = start_cnt;
    issue(24'($urandom), 8'd12);
    n = 0;
    while (start_cnt - s0 < HDR + DEPTH && n < 2000) begin step(); n++; end
    step(40);
    chk("stall_starts", start_cnt - s0, HDR + DEPTH);
    chk("stall_fifo_full", dut.fifo_cnt, DEPTH);
    chk("stall_cs_held", bus.spi_enable, 1);
    chk("stall_busy", bus.busy, 1);
    bus.rd_ready = 1'b1;
    wait_done("stall");

    // cmd_start while busy is ignored
    issue(24'h00F00D, 8'd5);
    step(6);
    bus.cmd_addr = 24'h777777; bus.cmd_len = 8'd9; bus.cmd_start = 1'b1;
    step();
    bus.cmd_start = 1'b0;
    wait_done("ignore");
    chk("ignore_tx_left", exp_tx.size(), 0);

    // reset while ADDR1 is on the wire, then a normal command
    s0 = start_cnt;
    issue(24'h5A5A5A, 8'd4);
    n = 0;
    while (start_cnt - s0 < 3 && n < 200) begin step(); n++; end
    chk("midrst_reached_addr1", start_cnt - s0, 3);
    reset = 1'b1;
    exp_tx.delete(); exp_rd.delete();
    step();
    chk_reset_outs("midrst");
    reset = 1'b0;
    step();
    issue(24'h123456, 8'd6);
    wait_done("after_rst");

    // stale bytes survive a new command and drain in order
    bus.rd_ready = 1'b0;
    issue(24'($urandom), 8'd3);
    wait_done("stale1");
    issue(24'($urandom), 8'd2);
    wait_done("stale2");
    chk("stale_fifo_cnt", dut.fifo_cnt, 5);
    bus.rd_ready = 1'b1;
    step(10);

    // full-rate random reads
    o0 = over1_cnt;
    for (int k = 0; k < 8; k++) begin
      a = 24'($urandom);
      l = 8'($urandom_range(1, 20));
      issue(a, l);
      wait_done("rand");
    end
    chk("fullrate_cnt_le1", over1_cnt - o0, 0);

    step(10);
    chk("final_tx_left", exp_tx.size(), 0);
    chk("final_rd_left", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
